// File: rtl/rsa_uart_host_ctrl.sv
// Host-side Avalon-MM master that feeds Rsa256Core from the RS232 UART and returns the result.
// Optional feature: define RSA_KEY_RELOAD_EN to reload n and d before every ciphertext.
module rsa_uart_host_ctrl #(
    parameter logic [4:0] ADDR_RX     = 5'd0,
    parameter logic [4:0] ADDR_TX     = 5'd4,
    parameter logic [4:0] ADDR_STATUS = 5'd8,
    parameter int         RX_OK_BIT   = 7,
    parameter int         TX_OK_BIT   = 6,
    parameter int         IN_BYTES    = 32,
    parameter int         OUT_BYTES   = 31
) (
    input  logic         i_clk,
    input  logic         i_rst,
    output logic [4:0]   avm_address,
    output logic         avm_read,
    input  logic [31:0]  avm_readdata,
    output logic         avm_write,
    output logic [31:0]  avm_writedata,
    input  logic         avm_waitrequest,
    output logic         o_rsa_start,
    output logic [255:0] o_rsa_a,
    output logic [255:0] o_rsa_d,
    output logic [255:0] o_rsa_n,
    input  logic [255:0] i_rsa_result,
    input  logic         i_rsa_finished
);

    typedef enum logic [2:0] {
        S_QUERY_RX  = 3'd0,
        S_READ      = 3'd1,
        S_START     = 3'd2,
        S_WAIT_CALC = 3'd3,
        S_QUERY_TX  = 3'd4,
        S_WRITE     = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        P_N = 2'd0,
        P_D = 2'd1,
        P_A = 2'd2
    } phase_t;

    localparam logic [4:0] IN_LAST  = 5'(IN_BYTES - 1);
    localparam logic [4:0] OUT_LAST = 5'(OUT_BYTES - 1);

`ifdef RSA_KEY_RELOAD_EN
    localparam phase_t PHASE_AFTER_TX = P_N;
`else
    localparam phase_t PHASE_AFTER_TX = P_A;
`endif

    state_t         state_r, state_s;
    phase_t         phase_r, phase_s;
    logic [4:0]     byte_cnt_r, byte_cnt_s;
    logic [255:0]   n_r, n_s, d_r, d_s, a_r, a_s;
    // Only the 31 transmitted bytes of the result are kept.
    logic [247:0]   result_r, result_s;
    logic [4:0]     address_r, address_s;
    logic           read_r, read_s;
    logic           write_r, write_s;
    logic [31:0]    writedata_r, writedata_s;
    logic           start_r, start_s;
    logic           xfer_done_s;
    logic [7:0]     rx_byte_s;

    // State, operand and registered-output update with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r     <= S_QUERY_RX;
            phase_r     <= P_N;
            byte_cnt_r  <= 5'd0;
            n_r         <= 256'd0;
            d_r         <= 256'd0;
            a_r         <= 256'd0;
            result_r    <= 248'd0;
            address_r   <= ADDR_STATUS;
            read_r      <= 1'b1;
            write_r     <= 1'b0;
            writedata_r <= 32'd0;
            start_r     <= 1'b0;
        end else begin
            state_r     <= state_s;
            phase_r     <= phase_s;
            byte_cnt_r  <= byte_cnt_s;
            n_r         <= n_s;
            d_r         <= d_s;
            a_r         <= a_s;
            result_r    <= result_s;
            address_r   <= address_s;
            read_r      <= read_s;
            write_r     <= write_s;
            writedata_r <= writedata_s;
            start_r     <= start_s;
        end
    end

    // Next-state, datapath and next-output decode.
    always_comb begin
        state_s     = state_r;
        phase_s     = phase_r;
        byte_cnt_s  = byte_cnt_r;
        n_s         = n_r;
        d_s         = d_r;
        a_s         = a_r;
        result_s    = result_r;
        address_s   = ADDR_STATUS;
        read_s      = 1'b0;
        write_s     = 1'b0;
        writedata_s = 32'd0;
        start_s     = 1'b0;
        xfer_done_s = (read_r | write_r) & ~avm_waitrequest;
        rx_byte_s   = avm_readdata[7:0];

        case (state_r)
            S_QUERY_RX: begin
                if (xfer_done_s && avm_readdata[RX_OK_BIT]) begin
                    state_s = S_READ;
                end else begin
                    state_s = S_QUERY_RX;
                end
            end
            S_READ: begin
                if (xfer_done_s) begin
                    case (phase_r)
                        P_N:     n_s = {n_r[247:0], rx_byte_s};
                        P_D:     d_s = {d_r[247:0], rx_byte_s};
                        P_A:     a_s = {a_r[247:0], rx_byte_s};
                        default: n_s = n_r;
                    endcase
                    if (byte_cnt_r == IN_LAST) begin
                        byte_cnt_s = 5'd0;
                        case (phase_r)
                            P_N: begin
                                phase_s = P_D;
                                state_s = S_QUERY_RX;
                            end
                            P_D: begin
                                phase_s = P_A;
                                state_s = S_QUERY_RX;
                            end
                            P_A: begin
                                phase_s = P_A;
                                state_s = S_START;
                            end
                            default: begin
                                phase_s = P_N;
                                state_s = S_QUERY_RX;
                            end
                        endcase
                    end else begin
                        byte_cnt_s = byte_cnt_r + 5'd1;
                        state_s    = S_QUERY_RX;
                    end
                end else begin
                    state_s = S_READ;
                end
            end
            S_START: begin
                state_s = S_WAIT_CALC;
            end
            S_WAIT_CALC: begin
                if (i_rsa_finished) begin
                    result_s   = i_rsa_result[247:0];
                    byte_cnt_s = 5'd0;
                    state_s    = S_QUERY_TX;
                end else begin
                    state_s = S_WAIT_CALC;
                end
            end
            S_QUERY_TX: begin
                if (xfer_done_s && avm_readdata[TX_OK_BIT]) begin
                    state_s = S_WRITE;
                end else begin
                    state_s = S_QUERY_TX;
                end
            end
            S_WRITE: begin
                if (xfer_done_s) begin
                    result_s = {result_r[239:0], 8'h00};
                    if (byte_cnt_r == OUT_LAST) begin
                        byte_cnt_s = 5'd0;
                        phase_s    = PHASE_AFTER_TX;
                        state_s    = S_QUERY_RX;
                    end else begin
                        byte_cnt_s = byte_cnt_r + 5'd1;
                        state_s    = S_QUERY_TX;
                    end
                end else begin
                    state_s = S_WRITE;
                end
            end
            default: begin
                state_s = S_QUERY_RX;
                phase_s = P_N;
            end
        endcase

        // Outputs follow the state being entered, so they hold steady during a stall.
        case (state_s)
            S_QUERY_RX, S_QUERY_TX: begin
                address_s = ADDR_STATUS;
                read_s    = 1'b1;
            end
            S_READ: begin
                address_s = ADDR_RX;
                read_s    = 1'b1;
            end
            S_START: begin
                start_s = 1'b1;
            end
            S_WRITE: begin
                address_s   = ADDR_TX;
                write_s     = 1'b1;
                writedata_s = {24'd0, result_s[247:240]};
            end
            default: begin
                address_s = ADDR_STATUS;
            end
        endcase
    end

    assign avm_address   = address_r;
    assign avm_read      = read_r;
    assign avm_write     = write_r;
    assign avm_writedata = writedata_r;
    assign o_rsa_start   = start_r;
    assign o_rsa_n       = n_r;
    assign o_rsa_d       = d_r;
    assign o_rsa_a       = a_r;

endmodule

// File: tb/tb_rsa_uart_host_ctrl.sv
// Directed bench for rsa_uart_host_ctrl: a UART slave model and a core model driven step by step.
// Honours RSA_KEY_RELOAD_EN the same way as the design.
module tb_rsa_uart_host_ctrl;

    logic         i_clk = 1'b0;
    logic         i_rst;
    logic [4:0]   avm_address;
    logic         avm_read;
    logic [31:0]  avm_readdata;
    logic         avm_write;
    logic [31:0]  avm_writedata;
    logic         avm_waitrequest;
    logic         o_rsa_start;
    logic [255:0] o_rsa_a, o_rsa_d, o_rsa_n;
    logic [255:0] i_rsa_result;
    logic         i_rsa_finished;

    int vectors = 0;
    int miscompares = 0;

    rsa_uart_host_ctrl dut (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_readdata    (avm_readdata),
        .avm_write       (avm_write),
        .avm_writedata   (avm_writedata),
        .avm_waitrequest (avm_waitrequest),
        .o_rsa_start     (o_rsa_start),
        .o_rsa_a         (o_rsa_a),
        .o_rsa_d         (o_rsa_d),
        .o_rsa_n         (o_rsa_n),
        .i_rsa_result    (i_rsa_result),
        .i_rsa_finished  (i_rsa_finished)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Serve one RX byte: busy polls answer RX not ready, then ready, then the data read.
    task automatic rx_byte(input logic [7:0] b, input int busy, output int polls, output bit ok);
        polls = 0;
        ok = 1'b0;
        for (int c = 0; c < 300 && !ok; c++) begin
            @(negedge i_clk);
            avm_waitrequest = 1'b0;
            avm_readdata = 32'd0;
            if (avm_read && avm_address == 5'd8) begin
                avm_readdata = (polls >= busy) ? 32'h0000_0080 : 32'h0000_0000;
                polls++;
            end else if (avm_read && avm_address == 5'd0) begin
                avm_readdata = {24'd0, b};
                ok = 1'b1;
            end
        end
    endtask

    // Accept one TX byte after busy not-ready polls; with hold the write is left stalled.
    task automatic tx_byte(input int busy, input bit hold, output logic [31:0] w, output bit ok);
        int polls;
        polls = 0;
        ok = 1'b0;
        w = 32'hdead_beef;
        for (int c = 0; c < 300 && !ok; c++) begin
            @(negedge i_clk);
            avm_waitrequest = 1'b0;
            avm_readdata = 32'd0;
            if (avm_read && avm_address == 5'd8) begin
                avm_readdata = (polls >= busy) ? 32'h0000_0040 : 32'h0000_0000;
                polls++;
            end else if (avm_write && avm_address == 5'd4) begin
                w = avm_writedata;
                ok = 1'b1;
                avm_waitrequest = hold;
            end
        end
    endtask

    task automatic send_operand(input logic [7:0] base, output bit all_ok);
        int p;
        bit ok;
        all_ok = 1'b1;
        for (int k = 0; k < 32; k++) begin
            rx_byte(base + 8'(k), 0, p, ok);
            all_ok &= ok;
        end
    endtask

    localparam logic [255:0] N1 = 256'h0102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f20;
    localparam logic [255:0] D1 = 256'h2122232425262728292a2b2c2d2e2f303132333435363738393a3b3c3d3e3f40;
    localparam logic [255:0] A1 = 256'h4142434445464748494a4b4c4d4e4f505152535455565758595a5b5c5d5e5f60;
    localparam logic [255:0] A2 = 256'h6162636465666768696a6b6c6d6e6f707172737475767778797a7b7c7d7e7f80;
    localparam logic [255:0] N2 = 256'h8182838485868788898a8b8c8d8e8f909192939495969798999a9b9c9d9e9fa0;
    localparam logic [255:0] D2 = 256'ha1a2a3a4a5a6a7a8a9aaabacadaeafb0b1b2b3b4b5b6b7b8b9babbbcbdbebfc0;
    localparam logic [255:0] A3 = 256'hc1c2c3c4c5c6c7c8c9cacbcccdcecfd0d1d2d3d4d5d6d7d8d9dadbdcdddedfe0;
    localparam logic [255:0] R1 = 256'hab1e1d1c1b1a191817161514131211100f0e0d0c0b0a09080706050403020100;

    initial begin
        int polls;
        bit ok;
        bit all_ok;
        logic [31:0] w;
        logic [255:0] r2;

        r2 = 256'd0;
        for (int k = 0; k < 31; k++) r2[8*k +: 8] = 8'hf0 ^ 8'(k);

        // Reset state
        i_rst = 1'b1;
        avm_readdata = 32'd0;
        avm_waitrequest = 1'b0;
        i_rsa_result = 256'd0;
        i_rsa_finished = 1'b0;
        repeat (2) @(negedge i_clk);
        chk("rst_read", {255'd0, avm_read}, 256'd1);
        chk("rst_addr", {251'd0, avm_address}, 256'd8);
        chk("rst_write", {255'd0, avm_write}, 256'd0);
        chk("rst_wdata", {224'd0, avm_writedata}, 256'd0);
        chk("rst_start", {255'd0, o_rsa_start}, 256'd0);
        chk("rst_n", o_rsa_n, 256'd0);
        chk("rst_d", o_rsa_d, 256'd0);
        chk("rst_a", o_rsa_a, 256'd0);
        i_rst = 1'b0;

        // A stray finished pulse while polling RX must be ignored.
        i_rsa_finished = 1'b1;
        i_rsa_result = {256{1'b1}};
        @(negedge i_clk);
        i_rsa_finished = 1'b0;
        chk("stray_fin_read", {255'd0, avm_read}, 256'd1);
        chk("stray_fin_addr", {251'd0, avm_address}, 256'd8);

        // Three-cycle stall on a status read: request must hold still.
        avm_waitrequest = 1'b1;
        for (int s = 0; s < 3; s++) begin
            @(negedge i_clk);
            chk("stall_read", {255'd0, avm_read}, 256'd1);
            chk("stall_addr", {251'd0, avm_address}, 256'd8);
        end
        avm_waitrequest = 1'b0;

        // First n byte after ten not-ready polls: eleven status reads in total.
        rx_byte(8'h01, 10, polls, ok);
        chk("rx_first_ok", {255'd0, ok}, 256'd1);
        chk("rx_poll_count", 256'(polls), 256'd11);
        all_ok = 1'b1;
        for (int k = 1; k < 32; k++) begin
            rx_byte(8'h01 + 8'(k), 0, polls, ok);
            all_ok &= ok;
        end
        chk("n_bytes_ok", {255'd0, all_ok}, 256'd1);
        @(negedge i_clk);
        chk("n_loaded", o_rsa_n, N1);
        chk("d_still_zero", o_rsa_d, 256'd0);

        send_operand(8'h21, all_ok);
        chk("d_bytes_ok", {255'd0, all_ok}, 256'd1);
        send_operand(8'h41, all_ok);
        chk("a_bytes_ok", {255'd0, all_ok}, 256'd1);

        // One start pulse with the bus idle.
        @(negedge i_clk);
        chk("start_hi", {255'd0, o_rsa_start}, 256'd1);
        chk("start_bus_idle", {254'd0, avm_read, avm_write}, 256'd0);
        chk("d_loaded", o_rsa_d, D1);
        chk("a_loaded", o_rsa_a, A1);
        @(negedge i_clk);
        chk("start_lo", {255'd0, o_rsa_start}, 256'd0);
        repeat (47) @(negedge i_clk);
        chk("calc_bus_idle", {254'd0, avm_read, avm_write}, 256'd0);
        i_rsa_result = R1;
        i_rsa_finished = 1'b1;
        @(negedge i_clk);
        i_rsa_finished = 1'b0;
        i_rsa_result = 256'd0;

        // 31 TX bytes, [247:240] first; the first waits on two not-ready polls.
        all_ok = 1'b1;
        for (int i = 0; i < 31; i++) begin
            tx_byte((i == 0) ? 2 : 0, 1'b0, w, ok);
            all_ok &= ok;
            chk("tx1_byte", {224'd0, w}, {248'd0, 8'(30 - i)});
        end
        chk("tx1_ok", {255'd0, all_ok}, 256'd1);

`ifdef RSA_KEY_RELOAD_EN
        // Every transaction reloads n, d, a; start only after the 96th byte.
        send_operand(8'h81, all_ok);
        chk("n2_bytes_ok", {255'd0, all_ok}, 256'd1);
        send_operand(8'ha1, all_ok);
        chk("d2_bytes_ok", {255'd0, all_ok}, 256'd1);
        chk("no_early_start", {255'd0, o_rsa_start}, 256'd0);
        send_operand(8'hc1, all_ok);
        chk("a2_bytes_ok", {255'd0, all_ok}, 256'd1);
        @(negedge i_clk);
        chk("start2_hi", {255'd0, o_rsa_start}, 256'd1);
        chk("n2_loaded", o_rsa_n, N2);
        chk("d2_loaded", o_rsa_d, D2);
        chk("a2_loaded", o_rsa_a, A3);
`else
        // Without reload only a is received again; n and d persist.
        send_operand(8'h61, all_ok);
        chk("a2_bytes_ok", {255'd0, all_ok}, 256'd1);
        @(negedge i_clk);
        chk("start2_hi", {255'd0, o_rsa_start}, 256'd1);
        chk("n_kept", o_rsa_n, N1);
        chk("d_kept", o_rsa_d, D1);
        chk("a2_loaded", o_rsa_a, A2);
`endif

        // Finished on the cycle right after start.
        @(negedge i_clk);
        chk("start2_lo", {255'd0, o_rsa_start}, 256'd0);
        i_rsa_result = r2;
        i_rsa_finished = 1'b1;
        @(negedge i_clk);
        i_rsa_finished = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tx_byte(0, 1'b0, w, ok);
            chk("tx2_byte", {224'd0, w}, {248'd0, 8'hf0 ^ 8'(30 - i)});
        end

        // Reset while write of byte 10 is stalled.
        tx_byte(0, 1'b1, w, ok);
        chk("tx2_byte10", {224'd0, w}, {248'd0, 8'hf0 ^ 8'd20});
        i_rst = 1'b1;
        @(negedge i_clk);
        chk("mid_rst_write", {255'd0, avm_write}, 256'd0);
        chk("mid_rst_read", {255'd0, avm_read}, 256'd1);
        chk("mid_rst_addr", {251'd0, avm_address}, 256'd8);
        chk("mid_rst_wdata", {224'd0, avm_writedata}, 256'd0);
        chk("mid_rst_ops", {253'd0, |o_rsa_n, |o_rsa_d, |o_rsa_a}, 256'd0);
        i_rst = 1'b0;
        avm_waitrequest = 1'b0;

        // Phase is back to n after reset.
        rx_byte(8'h5a, 0, polls, ok);
        chk("post_rst_rx_ok", {255'd0, ok}, 256'd1);
        @(negedge i_clk);
        chk("post_rst_n", o_rsa_n, 256'h5a);
        chk("post_rst_a", o_rsa_a, 256'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
